// File: rtl/pkt_prio_sched.sv
// pkt_prio_sched: classifies incoming packets by priority tag into NUM_CLASS
// FIFO queues and serves them through a single registered output stage.
// Class 0 is the highest priority. Tag 0 and packets hitting a full class are
// dropped and counted.
// Optional build macro PKT_SCHED_AGING_EN adds per-class age counters that let
// a starved lower class override strict priority once it reaches AGE_LIMIT.
module pkt_prio_sched #(
   parameter int DWIDTH      = 32,
   parameter int PRIOR_WIDTH = 6,
   parameter int NUM_CLASS   = 4,
   parameter int DEPTH       = 8,
   parameter int AGE_LIMIT   = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic [DWIDTH-1:0]            in_data,
   input  logic [PRIOR_WIDTH-1:0]       in_prior,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DWIDTH-1:0]            out_data,
   output logic [PRIOR_WIDTH-1:0]       out_prior,
   output logic [$clog2(NUM_CLASS)-1:0] out_class,
   output logic [NUM_CLASS-1:0]         class_full,
   output logic [15:0]                  drop_cnt
);

   localparam int CW = $clog2(NUM_CLASS);
   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;
   localparam int EW = PRIOR_WIDTH + DWIDTH;

   // queue storage: {prior, data} per entry; contents need no reset
   logic [EW-1:0]                 mem_q [NUM_CLASS][DEPTH];
   logic [NUM_CLASS-1:0][PW-1:0]  wptr_q, rptr_q;
   logic [NUM_CLASS-1:0][OW-1:0]  cnt_q;

   logic                          out_valid_q;
   logic [DWIDTH-1:0]             out_data_q;
   logic [PRIOR_WIDTH-1:0]        out_prior_q;
   logic [CW-1:0]                 out_class_q;
   logic [15:0]                   drop_cnt_q;

   logic [CW-1:0]                 in_cls;
   logic [NUM_CLASS-1:0]          ne, full, push, pop;
   logic                          accept, drop, load;
   logic [CW-1:0]                 sel;
   logic [EW-1:0]                 rd_ent;

   // map priority tag to class; tags above NUM_CLASS fold into the last class
   always_comb begin
      in_cls = '0;
      if (int'(in_prior) > NUM_CLASS)
         in_cls = CW'(NUM_CLASS - 1);
      else if (in_prior != '0)
         in_cls = CW'(in_prior - 1'b1);
   end

   // occupancy flags are taken from the registered counts, so a same-cycle
   // pop never rescues a packet aimed at a full class
   always_comb begin
      for (int c = 0; c < NUM_CLASS; c++) begin
         ne[c]   = (cnt_q[c] != '0);
         full[c] = (cnt_q[c] == OW'(DEPTH));
      end
   end

   assign drop   = in_valid && ((in_prior == '0) || full[in_cls]);
   assign accept = in_valid && (in_prior != '0) && !full[in_cls];
   assign load   = (!out_valid_q || out_ready) && (|ne);

`ifdef PKT_SCHED_AGING_EN
   localparam int AW = $clog2(AGE_LIMIT + 1);
   logic [NUM_CLASS-1:1][AW-1:0] age_q;
   logic [NUM_CLASS-1:1]         aged;

   // a class is starving once its age counter has saturated
   always_comb begin
      for (int c = 1; c < NUM_CLASS; c++)
         aged[c] = ne[c] && (age_q[c] == AW'(AGE_LIMIT));
   end

   // pick lowest non-empty class, then let the lowest starving class override
   always_comb begin
      sel = '0;
      for (int c = NUM_CLASS - 1; c >= 0; c--)
         if (ne[c]) sel = CW'(c);
      for (int c = NUM_CLASS - 1; c >= 1; c--)
         if (aged[c]) sel = CW'(c);
   end

   // age grows while a class waits, clears when served or drained
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age_q <= '0;
      end else begin
         for (int c = 1; c < NUM_CLASS; c++) begin
            if (pop[c] || !ne[c])
               age_q[c] <= '0;
            else if (age_q[c] != AW'(AGE_LIMIT))
               age_q[c] <= age_q[c] + 1'b1;
         end
      end
   end
`else
   // strict priority: lowest-index non-empty class wins
   always_comb begin
      sel = '0;
      for (int c = NUM_CLASS - 1; c >= 0; c--)
         if (ne[c]) sel = CW'(c);
   end
`endif

   // per-class push/pop strobes
   always_comb begin
      for (int c = 0; c < NUM_CLASS; c++) begin
         push[c] = accept && (in_cls == CW'(c));
         pop[c]  = load && (sel == CW'(c));
      end
   end

   assign rd_ent = mem_q[sel][rptr_q[sel]];

   // queue storage write
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CLASS; c++)
         if (push[c]) mem_q[c][wptr_q[c]] <= {in_prior, in_data};
   end

   // pointers wrap naturally at DEPTH; count holds on simultaneous push+pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         for (int c = 0; c < NUM_CLASS; c++) begin
            if (push[c]) wptr_q[c] <= wptr_q[c] + 1'b1;
            if (pop[c])  rptr_q[c] <= rptr_q[c] + 1'b1;
            if (push[c] && !pop[c])
               cnt_q[c] <= cnt_q[c] + 1'b1;
            else if (pop[c] && !push[c])
               cnt_q[c] <= cnt_q[c] - 1'b1;
         end
      end
   end

   // output register: refill whenever empty or consumed, else hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_prior_q <= '0;
         out_class_q <= '0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_data_q  <= rd_ent[DWIDTH-1:0];
         out_prior_q <= rd_ent[EW-1:DWIDTH];
         out_class_q <= sel;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // saturating drop counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_cnt_q <= '0;
      else if (drop && (drop_cnt_q != 16'hFFFF))
         drop_cnt_q <= drop_cnt_q + 16'd1;
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_prior  = out_prior_q;
   assign out_class  = out_class_q;
   assign class_full = full;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pkt_prio_sched.sv
// Directed bench for pkt_prio_sched with default parameters. Inputs change
// right after a falling edge; outputs are checked on the falling edge.
module tb_pkt_prio_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic [5:0]  in_prior;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [5:0]  out_prior;
   logic [1:0]  out_class;
   logic [3:0]  class_full;
   logic [15:0] drop_cnt;

   int errors = 0;
   int checks = 0;
   int first3;

   pkt_prio_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_prior   (in_prior),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_prior  (out_prior),
      .out_class  (out_class),
      .class_full (class_full),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [5:0] p, input logic [31:0] d);
      in_valid = 1'b1;
      in_prior = p;
      in_data  = d;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_prior = '0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_full", class_full, 0);
      chk("rst_drop", drop_cnt, 0);
      rst_n = 1'b1;

      // single packet, 2-cycle latency
      out_ready = 1'b1;
      put(6'd3, 32'hA5A5A5A5);
      in_valid = 1'b0;
      chk("lat_early", out_valid, 0);
      tick();
      chk("lat_valid", out_valid, 1);
      chk("lat_class", out_class, 2);
      chk("lat_data", out_data, 32'hA5A5A5A5);
      tick();
      chk("lat_clear", out_valid, 0);

      // fill class 0 behind a stalled output; 9th packet drops
      out_ready = 1'b0;
      put(6'd4, 32'h333);
      for (int i = 0; i < 9; i++) put(6'd1, 32'(i));
      in_valid = 1'b0;
      chk("full_flag", class_full, 4'b0001);
      chk("full_drop", drop_cnt, 1);
      chk("full_head", out_data, 32'h333);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("fifo_data%0d", i), out_data, 32'(i));
         chk($sformatf("fifo_vld%0d", i), out_valid, 1);
      end
      tick();
      chk("fifo_done", out_valid, 0);
      chk("fifo_full0", class_full, 0);

      // strict priority: class 0 overtakes earlier-queued class 3
      out_ready = 1'b0;
      put(6'd2, 32'hF1);
      put(6'd4, 32'h44);
      put(6'd1, 32'h11);
      in_valid = 1'b0;
      chk("prio_head", out_data, 32'hF1);
      out_ready = 1'b1;
      tick();
      chk("prio_c0_data", out_data, 32'h11);
      chk("prio_c0_class", out_class, 0);
      tick();
      chk("prio_c3_data", out_data, 32'h44);
      chk("prio_c3_prior", out_prior, 4);
      tick();
      chk("prio_done", out_valid, 0);

      // tag 0 drops, oversize tag folds into last class
      put(6'd0, 32'hDEAD);
      put(6'd40, 32'hBEEF);
      in_valid = 1'b0;
      tick();
      chk("map_valid", out_valid, 1);
      chk("map_class", out_class, 3);
      chk("map_prior", out_prior, 40);
      chk("map_data", out_data, 32'hBEEF);
      chk("map_drop", drop_cnt, 2);
      tick();

      // class 0 fed continuously while class 3 waits
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) put(6'd1, 32'h50 + 32'(i));
      put(6'd4, 32'h99);
      out_ready = 1'b1;
      first3 = 0;
      for (int k = 1; k <= 40; k++) begin
         put(6'd1, 32'h100 + 32'(k));
         if (out_valid && out_class == 2'd3 && first3 == 0) first3 = k;
      end
      in_valid = 1'b0;
`ifdef PKT_SCHED_AGING_EN
      chk("age_served_at", first3, 17);
`else
      chk("age_starved", first3, 0);
`endif
      for (int i = 0; i < 20; i++) tick();
      chk("age_drain_vld", out_valid, 0);
      chk("age_drain_full", class_full, 0);
      chk("age_no_drop", drop_cnt, 2);

      // reset mid-operation with packets queued
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) put(6'd2, 32'h60 + 32'(i));
      in_valid = 1'b0;
      chk("mid_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_full", class_full, 0);
      chk("mid_rst_drop", drop_cnt, 0);
      chk("mid_rst_data", out_data, 0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick(); tick(); tick();
      chk("post_rst_stale", out_valid, 0);
      put(6'd1, 32'h77);
      in_valid = 1'b0;
      tick();
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_data", out_data, 32'h77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
